// File: rtl/alu_share_ctrl_if.sv
// Bundle of requester handshakes and ALU connections for alu_share_ctrl.
// The slave modport is the controller's view; master is the requesters/ALU side.
interface alu_share_ctrl_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FUNC_W = 3
);
    logic              req0;
    logic              req1;
    logic [WIDTH-1:0]  aIn0;
    logic [WIDTH-1:0]  bIn0;
    logic [WIDTH-1:0]  aIn1;
    logic [WIDTH-1:0]  bIn1;
    logic [FUNC_W-1:0] funcIn0;
    logic [FUNC_W-1:0] funcIn1;
    logic              useC0;
    logic              useC1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [WIDTH-1:0]  resOut;
    logic              coOut;
    logic              zOut;
    logic              nOut;
    logic              busy;
    logic [WIDTH-1:0]  aluA;
    logic [WIDTH-1:0]  aluB;
    logic [FUNC_W-1:0] aluFunc;
    logic              aluCi;
    logic [WIDTH-1:0]  aluRes;
    logic              aluCo;
    logic              aluZ;
    logic              aluN;

    modport slave (
        input  req0, req1, aIn0, bIn0, aIn1, bIn1, funcIn0, funcIn1, useC0, useC1,
        input  aluRes, aluCo, aluZ, aluN,
        output gnt0, gnt1, done0, done1, resOut, coOut, zOut, nOut, busy,
        output aluA, aluB, aluFunc, aluCi
    );

    modport master (
        output req0, req1, aIn0, bIn0, aIn1, bIn1, funcIn0, funcIn1, useC0, useC1,
        output aluRes, aluCo, aluZ, aluN,
        input  gnt0, gnt1, done0, done1, resOut, coOut, zOut, nOut, busy,
        input  aluA, aluB, aluFunc, aluCi
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin tie-break.
// Each requester owns a private carry flag so interleaved multi-byte chains stay intact.
module alu_share_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FUNC_W = 3
) (
    input logic              clk,
    input logic              rst,
    alu_share_ctrl_if.slave  bus
);
    typedef enum logic {StIdle, StExec} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_win1;

    logic [WIDTH-1:0]  r_opA;
    logic [WIDTH-1:0]  r_opB;
    logic [FUNC_W-1:0] r_opF;
    logic              r_opU;
    logic              r_owner;
    logic              r_lastGnt;
    logic [1:0]        r_cFlag;
    logic [WIDTH-1:0]  r_res;
    logic              r_co;
    logic              r_z;
    logic              r_n;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;

    // Requester 1 wins if alone, or on a tie when requester 0 was granted last.
    always_comb begin
        w_win1 = bus.req1 & (~bus.req0 | ~r_lastGnt);
    end

    // Next-state: accept only from idle, execution always lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    w_accept     = 1'b1;
                    w_state_next = StExec;
                end
            end
            StExec:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, result capture, carry flags and handshake pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA     <= '0;
            r_opB     <= '0;
            r_opF     <= '0;
            r_opU     <= 1'b0;
            r_owner   <= 1'b0;
            r_lastGnt <= 1'b1;
            r_cFlag   <= 2'b00;
            r_res     <= '0;
            r_co      <= 1'b0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
        end else begin
            r_gnt0  <= w_accept & ~w_win1;
            r_gnt1  <= w_accept & w_win1;
            r_done0 <= (r_state == StExec) & ~r_owner;
            r_done1 <= (r_state == StExec) & r_owner;
            if (w_accept) begin
                r_opA     <= w_win1 ? bus.aIn1 : bus.aIn0;
                r_opB     <= w_win1 ? bus.bIn1 : bus.bIn0;
                r_opF     <= w_win1 ? bus.funcIn1 : bus.funcIn0;
                r_opU     <= w_win1 ? bus.useC1 : bus.useC0;
                r_owner   <= w_win1;
                r_lastGnt <= w_win1;
            end
            if (r_state == StExec) begin
                r_res            <= bus.aluRes;
                r_co             <= bus.aluCo;
                r_z              <= bus.aluZ;
                r_n              <= bus.aluN;
                // Carry-out always updates the owner's flag, even when carry-in was unused.
                r_cFlag[r_owner] <= bus.aluCo;
            end
        end
    end

    assign bus.aluA    = r_opA;
    assign bus.aluB    = r_opB;
    assign bus.aluFunc = r_opF;
    assign bus.aluCi   = r_opU & r_cFlag[r_owner];
    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;
    assign bus.resOut  = r_res;
    assign bus.coOut   = r_co;
    assign bus.zOut    = r_z;
    assign bus.nOut    = r_n;
    assign bus.busy    = (r_state != StIdle);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU stub.
module tb_alu_share_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fails;

    alu_share_ctrl_if #(.WIDTH(8), .FUNC_W(3)) bus ();

    alu_share_ctrl #(.WIDTH(8), .FUNC_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: 000 add with carry, 001 subtract, 010 and, 011 or, 100 xor, else pass A.
    logic [8:0] w_sum;
    always_comb begin
        w_sum = 9'd0;
        case (bus.aluFunc)
            3'b000:  w_sum = {1'b0, bus.aluA} + {1'b0, bus.aluB} + {8'd0, bus.aluCi};
            3'b001:  w_sum = {1'b0, bus.aluA} - {1'b0, bus.aluB} - {8'd0, bus.aluCi};
            3'b010:  w_sum = {1'b0, bus.aluA & bus.aluB};
            3'b011:  w_sum = {1'b0, bus.aluA | bus.aluB};
            3'b100:  w_sum = {1'b0, bus.aluA ^ bus.aluB};
            default: w_sum = {1'b0, bus.aluA};
        endcase
    end
    assign bus.aluRes = w_sum[7:0];
    assign bus.aluCo  = w_sum[8];
    assign bus.aluZ   = (w_sum[7:0] == 8'h00);
    assign bus.aluN   = w_sum[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit who, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] f, input bit u);
        if (who) begin
            bus.req1 = 1'b1; bus.aIn1 = a; bus.bIn1 = b; bus.funcIn1 = f; bus.useC1 = u;
        end else begin
            bus.req0 = 1'b1; bus.aIn0 = a; bus.bIn0 = b; bus.funcIn0 = f; bus.useC0 = u;
        end
    endtask

    // One complete operation from a single requester, called just after a rising edge.
    task automatic run_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] f, input bit u, input logic [7:0] eres,
                          input bit eco, input bit ez, input bit en, input bit eci);
        set_req(who, a, b, f, u);
        @(posedge clk); #1;
        check("gnt_owner", who ? bus.gnt1 : bus.gnt0, 1);
        check("gnt_other", who ? bus.gnt0 : bus.gnt1, 0);
        check("busy_exec", bus.busy, 1);
        check("aluA", bus.aluA, a);
        check("aluB", bus.aluB, b);
        check("aluFunc", bus.aluFunc, f);
        check("aluCi", bus.aluCi, eci);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        check("done_owner", who ? bus.done1 : bus.done0, 1);
        check("done_other", who ? bus.done0 : bus.done1, 0);
        check("gnt_at_done", {bus.gnt1, bus.gnt0}, 0);
        check("busy_done", bus.busy, 0);
        check("resOut", bus.resOut, eres);
        check("coOut", bus.coOut, eco);
        check("zOut", bus.zOut, ez);
        check("nOut", bus.nOut, en);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fails = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.aIn0 = 8'h00; bus.bIn0 = 8'h00; bus.aIn1 = 8'h00; bus.bIn1 = 8'h00;
        bus.funcIn0 = 3'b000; bus.funcIn1 = 3'b000; bus.useC0 = 1'b0; bus.useC1 = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
        check("rst_done", {bus.done1, bus.done0}, 0);
        check("rst_res", bus.resOut, 0);
        check("rst_flags", {bus.coOut, bus.zOut, bus.nOut}, 0);
        check("rst_aluA", bus.aluA, 0);
        check("rst_aluB", bus.aluB, 0);
        check("rst_aluF", bus.aluFunc, 0);
        check("rst_aluCi", bus.aluCi, 0);
        rst = 1'b0;

        // Basic add.
        run_op(1'b0, 8'h0F, 8'h01, 3'b000, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

        // Carry chain on requester 0.
        run_op(1'b0, 8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);

        // Carry isolation: requester 1 must not see requester 0's carry.
        run_op(1'b0, 8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(1'b1, 8'h00, 8'h00, 3'b000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Both requests held from reset: grants alternate 0,1,0,1.
        rst = 1'b1;
        set_req(1'b0, 8'h01, 8'h02, 3'b000, 1'b0);
        set_req(1'b1, 8'h10, 8'h20, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("tie_gnt", {bus.gnt1, bus.gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("tie_busy", bus.busy, 1);
            check("tie_aluA", bus.aluA, (i % 2 == 0) ? 8'h01 : 8'h10);
            @(posedge clk); #1;
            check("tie_done", {bus.done1, bus.done0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("tie_nognt", {bus.gnt1, bus.gnt0}, 2'b00);
            check("tie_res", bus.resOut, (i % 2 == 0) ? 8'h03 : 8'h30);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        do_reset();

        // Reset asserted during execution abandons the op and clears carry flags.
        run_op(1'b0, 8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        set_req(1'b0, 8'h7F, 8'h01, 3'b000, 1'b1);
        @(posedge clk); #1;
        check("rx_gnt", bus.gnt0, 1);
        check("rx_ci_pre", bus.aluCi, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rx_busy", bus.busy, 0);
        check("rx_gnt0", bus.gnt0, 0);
        check("rx_aluA", bus.aluA, 0);
        check("rx_aluCi", bus.aluCi, 0);
        check("rx_flags", {bus.coOut, bus.zOut, bus.nOut}, 0);
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        check("rx_nodone", {bus.done1, bus.done0}, 0);
        rst = 1'b0;
        run_op(1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Negative result, then a non-add function code passed through.
        run_op(1'b0, 8'h70, 8'h20, 3'b000, 1'b0, 8'h90, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(1'b1, 8'h0F, 8'hF0, 3'b100, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Results hold while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_res", bus.resOut, 8'hFF);
        check("hold_done", {bus.done1, bus.done0}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
